uart_core: RTL and testbench
============================

// Module: uart_core
// PURPOSE
//  Full-duplex 8N1 UART: baud tick generator, 16x-oversampling receiver and transmitter in one clock domain.
//  Sits between a byte-wide host interface and the serial pins; TX and RX run independently.
//  Ticks are single-cycle clock enables, never derived clocks.
// PARAMETERS
//  CLOCK_RATE  50000000  system clock frequency, Hz
//  BAUD_RATE   115200    line rate, bit/s
//  RX_DIV = CLOCK_RATE/(BAUD_RATE*16), truncated (27); TX_DIV = CLOCK_RATE/BAUD_RATE, truncated (434). Both are derived localparams.
// PORTS
//  One clock; reset is asynchronous and active-low.
//  clk      in   1  system clock, rising edge
//  rst_n    in   1  asynchronous active-low reset
//  rx_en    in   1  receiver enable
//  rx_in    in   1  serial input, idle high, asynchronous to clk
//  rx_data  out  8  last good received byte
//  rx_done  out  1  one-clk pulse: rx_data updated
//  rx_busy  out  1  frame reception in progress
//  rx_err   out  1  framing error flag
//  tx_en    in   1  transmitter enable
//  tx_start in   1  level request to send tx_data
//  tx_data  in   8  byte to send, latched at frame start
//  tx_out   out  1  serial output, idle high
//  tx_done  out  1  one-clk pulse at end of stop bit
//  tx_busy  out  1  frame transmission in progress
// BEHAVIOUR
//  Reset values: rx_data=0, rx_done=0, rx_busy=0, rx_err=0, tx_out=1, tx_done=0, tx_busy=0; counters=0; both FSMs IDLE.
//  Tick gen: rx_tick pulses 1 clk every RX_DIV clks; tx_tick pulses 1 clk every TX_DIV clks. Counters are free-running 0..DIV-1.
//  RX input: 2-FF synchronizer, reset value 1. RX FSM advances only on rx_tick. A 4-bit sample counter (0..15) runs per bit.
//   IDLE: if rx_en and sync_in==0 -> START, cnt=0.
//   START: on the 8th tick (cnt==7), re-sample the line.
//     Line high -> back to IDLE (glitch; no error).
//     Line low -> cnt=0 -> DATA.
//   DATA: sample at every 16th tick (mid-bit); shift LSB first; after 8 bits -> STOP.
//   STOP: sample at the 16th tick.
//     Line 1 -> rx_data<=shift, rx_done=1 for one clk, rx_err<=0 -> IDLE.
//     Line 0 -> rx_err<=1, rx_data unchanged, no rx_done -> BREAK.
//   BREAK: wait for sync_in==1 -> IDLE. This prevents re-triggering on a held-low line.
//   rx_err is sticky until the next validated start bit; it clears on entry to DATA.
//   rx_busy=1 in START, DATA and STOP.
//   rx_en low: FSM -> IDLE on the next clk, frame aborted, rx_busy=0; rx_data and rx_err hold.
//  TX FSM advances only on tx_tick; each state bit lasts one tick.
//   IDLE: tx_out=1. On a tick with tx_en && tx_start: latch tx_data -> START.
//   START: tx_out=0 (1 bit).
//   DATA: 8 bits LSB first.
//   STOP: tx_out=1 (1 bit), then tx_done for one clk.
//     tx_en && tx_start still high -> latch the new byte -> START (back-to-back, no idle gap).
//     Otherwise -> IDLE.
//   tx_busy=1 in START, DATA and STOP. tx_data changes mid-frame are ignored.
//   tx_en low: -> IDLE on the next clk, tx_out=1 immediately, tx_busy=0, no tx_done.
//  Frame time = 10*TX_DIV clks. rx_done occurs ~9.5 bit times after the start edge, plus 2 clks of sync.
//  Simultaneous RX/TX activity is fully independent. Reset mid-frame aborts both immediately to reset values.
// STRUCTURE
//  Package uart_pkg holds:
//   - rx/tx state enums (IDLE, START, DATA, STOP, BREAK)
//   - OVERSAMPLE=16
//   - DATA_BITS=8
//   - divisor functions
//  Sub-modules: uart_baud_tick (both dividers), uart_rx_fsm, uart_tx_fsm. uart_core only wires these together.
// TESTING
//  1. TX: tx_en=1, tx_start=1, tx_data=0x14 -> tx_out = 0|0,0,1,0,1,0,0,0|1, each bit 434 clks. tx_done pulses; the next frame follows immediately.
//  2. RX good frame 0xA5, bit time 8680 ns -> rx_data=0xA5, one rx_done pulse, rx_err=0, rx_busy high ~9.5 bits.
//  3. RX bits 0x05 with stop=0, then line high -> rx_err=1, no rx_done, rx_data unchanged. A following good 0x3C frame gives rx_data=0x3C and rx_err=0.
//  4. RX 2 us low glitch on idle line -> rx_busy returns low after ~8 ticks; no done, no err.
//  5. Loopback tx_out->rx_in, bytes 0x00, 0xFF, 0x55 back-to-back -> each received exactly once, in order.
//  6. rst_n low mid-frame (TX bit 4, RX bit 3) -> all outputs at reset values at once; after release the idle line yields no spurious done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART: state encodings, frame
// geometry and the divisor arithmetic used by the baud tick generator.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int DATA_BITS    = 8;
  localparam int SAMPLE_CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_CNT_W    = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rxStateT;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txStateT;

  // Clocks per receiver sample tick (16 ticks per bit), truncated.
  function automatic int rxDivisor(input int clockRate, input int baudRate);
    return clockRate / (baudRate * OVERSAMPLE);
  endfunction

  // Clocks per transmitted bit, truncated.
  function automatic int txDivisor(input int clockRate, input int baudRate);
    return clockRate / baudRate;
  endfunction

  // Width of a counter that must hold 0..div-1.
  function automatic int counterWidth(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Generates the receiver oversampling tick and the transmitter bit tick.
// Both are single-cycle clock enables from free-running counters.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic rst_n,
  output logic rxTick,
  output logic txTick
);

  localparam int RX_DIV = rxDivisor(CLOCK_RATE, BAUD_RATE);
  localparam int TX_DIV = txDivisor(CLOCK_RATE, BAUD_RATE);
  // The TX divisor is always the larger one, so it sets the shared width.
  localparam int CNT_W  = counterWidth(TX_DIV);

  logic [1:0] tickVec;

  // Index 0 is the RX divider, index 1 the TX divider.
  for (genvar gi = 0; gi < 2; gi++) begin : gDiv
    localparam int DIV = (gi == 0) ? RX_DIV : TX_DIV;

    logic [CNT_W-1:0] divCnt;
    logic             tickReg;

    // Count 0..DIV-1 and raise a one-clock enable on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        divCnt  <= '0;
        tickReg <= 1'b0;
      end else if (divCnt == CNT_W'(DIV - 1)) begin
        divCnt  <= '0;
        tickReg <= 1'b1;
      end else begin
        divCnt  <= divCnt + CNT_W'(1);
        tickReg <= 1'b0;
      end
    end

    assign tickVec[gi] = tickReg;
  end

  assign rxTick = tickVec[0];
  assign txTick = tickVec[1];

endmodule

// File: rtl/uart_rx_fsm.sv
// 16x-oversampling 8N1 receiver. The asynchronous line is synchronized,
// the start bit is validated at mid-bit, data and stop are sampled at
// every 16th tick after that, and a low stop bit parks the FSM in BREAK
// until the line returns high.
module uart_rx_fsm
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxTick,
  input  logic                 rx_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_err
);

  localparam logic [SAMPLE_CNT_W-1:0] MID_SAMPLE  = SAMPLE_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_CNT_W-1:0] LAST_SAMPLE = SAMPLE_CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0]    LAST_BIT    = BIT_CNT_W'(DATA_BITS - 1);

  logic [1:0]              syncReg;
  logic                    syncIn;
  rxStateT                 state;
  logic [SAMPLE_CNT_W-1:0] sampleCnt;
  logic [BIT_CNT_W-1:0]    bitCnt;
  logic [DATA_BITS-1:0]    shiftReg;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncReg <= 2'b11;
    end else begin
      syncReg <= {syncReg[0], rx_in};
    end
  end

  assign syncIn = syncReg[1];

  // Receive state machine; advances on rxTick, aborts at once when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      sampleCnt <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (!rx_en) begin
        state     <= RX_IDLE;
        sampleCnt <= '0;
        bitCnt    <= '0;
        rx_busy   <= 1'b0;
      end else if (rxTick) begin
        case (state)
          RX_IDLE: begin
            if (!syncIn) begin
              state     <= RX_START;
              sampleCnt <= '0;
              rx_busy   <= 1'b1;
            end
          end
          RX_START: begin
            if (sampleCnt == MID_SAMPLE) begin
              sampleCnt <= '0;
              if (syncIn) begin
                // Line went back high before mid-start: a glitch, not a frame.
                state   <= RX_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state  <= RX_DATA;
                bitCnt <= '0;
                rx_err <= 1'b0;
              end
            end else begin
              sampleCnt <= sampleCnt + SAMPLE_CNT_W'(1);
            end
          end
          RX_DATA: begin
            if (sampleCnt == LAST_SAMPLE) begin
              sampleCnt <= '0;
              shiftReg  <= {syncIn, shiftReg[DATA_BITS-1:1]};
              if (bitCnt == LAST_BIT) begin
                state <= RX_STOP;
              end else begin
                bitCnt <= bitCnt + BIT_CNT_W'(1);
              end
            end else begin
              sampleCnt <= sampleCnt + SAMPLE_CNT_W'(1);
            end
          end
          RX_STOP: begin
            if (sampleCnt == LAST_SAMPLE) begin
              sampleCnt <= '0;
              rx_busy   <= 1'b0;
              if (syncIn) begin
                rx_data <= shiftReg;
                rx_done <= 1'b1;
                rx_err  <= 1'b0;
                state   <= RX_IDLE;
              end else begin
                rx_err <= 1'b1;
                state  <= RX_BREAK;
              end
            end else begin
              sampleCnt <= sampleCnt + SAMPLE_CNT_W'(1);
            end
          end
          RX_BREAK: begin
            // Hold off until the line is released so a held-low line cannot retrigger.
            if (syncIn) begin
              state <= RX_IDLE;
            end
          end
          default: begin
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// 8N1 transmitter. Each frame element lasts exactly one txTick period;
// the byte is captured at frame start so host changes mid-frame are
// ignored, and a still-asserted request chains frames with no idle gap.
module uart_tx_fsm
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 txTick,
  input  logic                 tx_en,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_done,
  output logic                 tx_busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  txStateT              state;
  logic [BIT_CNT_W-1:0] bitCnt;
  logic [DATA_BITS-1:0] shiftReg;

  // Transmit state machine; advances on txTick, drops to idle when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_en) begin
        state   <= TX_IDLE;
        bitCnt  <= '0;
        tx_out  <= 1'b1;
        tx_busy <= 1'b0;
      end else if (txTick) begin
        case (state)
          TX_IDLE: begin
            tx_out <= 1'b1;
            if (tx_start) begin
              shiftReg <= tx_data;
              tx_out   <= 1'b0;
              tx_busy  <= 1'b1;
              state    <= TX_START;
            end
          end
          TX_START: begin
            tx_out   <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[DATA_BITS-1:1]};
            bitCnt   <= '0;
            state    <= TX_DATA;
          end
          TX_DATA: begin
            if (bitCnt == LAST_BIT) begin
              tx_out <= 1'b1;
              state  <= TX_STOP;
            end else begin
              tx_out   <= shiftReg[0];
              shiftReg <= {1'b0, shiftReg[DATA_BITS-1:1]};
              bitCnt   <= bitCnt + BIT_CNT_W'(1);
            end
          end
          TX_STOP: begin
            tx_done <= 1'b1;
            if (tx_start) begin
              // Back-to-back: the next start bit begins right after this stop bit.
              shiftReg <= tx_data;
              tx_out   <= 1'b0;
              state    <= TX_START;
            end else begin
              tx_busy <= 1'b0;
              state   <= TX_IDLE;
            end
          end
          default: begin
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            state   <= TX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART top: baud tick generator feeding independent
// receiver and transmitter state machines in one clock domain.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_err,
  input  logic                 tx_en,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_done,
  output logic                 tx_busy
);

  logic rxTick;
  logic txTick;

  uart_baud_tick #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) baudTick (
    .clk   (clk),
    .rst_n (rst_n),
    .rxTick(rxTick),
    .txTick(txTick)
  );

  uart_rx_fsm rxFsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxTick (rxTick),
    .rx_en  (rx_en),
    .rx_in  (rx_in),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rx_busy(rx_busy),
    .rx_err (rx_err)
  );

  uart_tx_fsm txFsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .txTick  (txTick),
    .tx_en   (tx_en),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_out  (tx_out),
    .tx_done (tx_done),
    .tx_busy (tx_busy)
  );

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core at 50 MHz / 115200 baud.
// Received bytes are checked against a scoreboard queue filled when the
// serial stimulus (or the looped-back transmitter) is launched.
`timescale 1ns/1ps
module tb_uart_core;

  localparam int BIT_CLKS = 434;
  localparam int BIT_NS   = 8680;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_en    = 1'b0;
  logic       tx_en    = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       rxDrive  = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, rx_err, tx_out, tx_done, tx_busy;

  int checks      = 0;
  int failures    = 0;
  int rxDoneCount = 0;
  int txDoneCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] expByte;

  assign rx_in = loopback ? tx_out : rxDrive;

  always #10 clk = ~clk;

  uart_core #(
    .CLOCK_RATE(50000000),
    .BAUD_RATE (115200)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_en   (rx_en),
    .rx_in   (rx_in),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_busy (rx_busy),
    .rx_err  (rx_err),
    .tx_en   (tx_en),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_out  (tx_out),
    .tx_done (tx_done),
    .tx_busy (tx_busy)
  );

  // Scoreboard: every rx_done pops one expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done) begin
        rxDoneCount++;
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL rx_unexpected got=%02h expected=none", rx_data);
        end else begin
          expByte = expQ.pop_front();
          if (rx_data !== expByte) begin
            failures++;
            $display("FAIL rx_byte got=%02h expected=%02h", rx_data, expByte);
          end else begin
            $display("rx byte=%02h expected=%02h", rx_data, expByte);
          end
        end
      end
      if (tx_done) txDoneCount++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_rx_frame(input logic [7:0] b, input logic stopBit);
    rxDrive = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rxDrive = b[i];
      #(BIT_NS);
    end
    rxDrive = stopBit;
    #(BIT_NS);
    rxDrive = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({rx_data, rx_done, rx_busy, rx_err, tx_out, tx_done, tx_busy} !== 14'b00000000_000100) begin
      failures++;
      $display("FAIL reset_values got=%b expected=%b",
               {rx_data, rx_done, rx_busy, rx_err, tx_out, tx_done, tx_busy}, 14'b00000000_000100);
    end
    rst_n = 1'b1;
    rx_en = 1'b1;
    tx_en = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if ({rx_busy, tx_busy, tx_out, rx_done, tx_done} !== 5'b00100) begin
      failures++;
      $display("FAIL idle_after_reset got=%b expected=%b", {rx_busy, tx_busy, tx_out, rx_done, tx_done}, 5'b00100);
    end
    $display("reset test complete");
  endtask

  task automatic test_tx();
    logic [9:0] frame;
    int n;
    int doneBefore;
    logic expOut, expBusy;
    frame = {1'b1, 8'h14, 1'b0};
    doneBefore = txDoneCount;
    @(negedge clk);
    tx_data  = 8'h14;
    tx_start = 1'b1;
    n = 0;
    while (tx_out !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL tx_start_edge got=timeout expected=start bit");
      tx_start = 1'b0;
      return;
    end
    for (int f = 0; f < 2; f++) begin
      repeat (BIT_CLKS / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (tx_out !== frame[i]) begin
          failures++;
          $display("FAIL tx_bit frame=%0d bit=%0d got=%b expected=%b", f, i, tx_out, frame[i]);
        end
        if (i == 5) begin
          checks++;
          if (tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL tx_busy_mid got=%b expected=1", tx_busy);
          end
        end
        if (i < 9) repeat (BIT_CLKS) @(negedge clk);
      end
      n = 0;
      while (tx_done !== 1'b1 && n < BIT_CLKS) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= BIT_CLKS) begin
        failures++;
        $display("FAIL tx_done_timeout frame=%0d got=none expected=pulse", f);
      end
      // First frame chains into the next start bit; second returns to idle.
      expOut  = (f == 0) ? 1'b0 : 1'b1;
      expBusy = (f == 0) ? 1'b1 : 1'b0;
      checks++;
      if (tx_out !== expOut || tx_busy !== expBusy) begin
        failures++;
        $display("FAIL tx_after_stop frame=%0d got=out%b/busy%b expected=out%b/busy%b",
                 f, tx_out, tx_busy, expOut, expBusy);
      end
      tx_data  = 8'hFF;
      tx_start = 1'b0;
      $display("tx frame %0d of byte 14 sent", f);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin
      failures++;
      $display("FAIL tx_done_width got=%b expected=0", tx_done);
    end
    checks++;
    if (txDoneCount - doneBefore !== 2) begin
      failures++;
      $display("FAIL tx_done_count got=%0d expected=2", txDoneCount - doneBefore);
    end
  endtask

  task automatic test_rx_good();
    int doneBefore;
    @(negedge clk);
    doneBefore = rxDoneCount;
    expQ.push_back(8'hA5);
    fork
      drive_rx_frame(8'hA5, 1'b1);
      begin
        #(BIT_NS * 5);
        checks++;
        if (rx_busy !== 1'b1) begin
          failures++;
          $display("FAIL rx_busy_mid got=%b expected=1", rx_busy);
        end
      end
    join
    #(BIT_NS / 2);
    checks++;
    if (rxDoneCount - doneBefore !== 1 || rx_data !== 8'hA5 || rx_err !== 1'b0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL rx_good got=done%0d/data%02h/err%b/busy%b expected=done1/dataa5/err0/busy0",
               rxDoneCount - doneBefore, rx_data, rx_err, rx_busy);
    end
  endtask

  task automatic test_rx_framing();
    int doneBefore;
    logic [7:0] prevData;
    @(negedge clk);
    doneBefore = rxDoneCount;
    prevData   = rx_data;
    drive_rx_frame(8'h05, 1'b0);
    #(BIT_NS);
    checks++;
    if (rx_err !== 1'b1 || rxDoneCount !== doneBefore || rx_data !== prevData) begin
      failures++;
      $display("FAIL rx_framing got=err%b/done%0d/data%02h expected=err1/done0/data%02h",
               rx_err, rxDoneCount - doneBefore, rx_data, prevData);
    end
    $display("rx framing-error frame 05 injected");
    expQ.push_back(8'h3C);
    drive_rx_frame(8'h3C, 1'b1);
    #(BIT_NS / 2);
    checks++;
    if (rx_data !== 8'h3C || rx_err !== 1'b0 || rxDoneCount - doneBefore !== 1) begin
      failures++;
      $display("FAIL rx_recover got=data%02h/err%b/done%0d expected=data3c/err0/done1",
               rx_data, rx_err, rxDoneCount - doneBefore);
    end
  endtask

  task automatic test_glitch();
    int doneBefore;
    @(negedge clk);
    doneBefore = rxDoneCount;
    rxDrive = 1'b0;
    #1000;
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_rise got=%b expected=1", rx_busy);
    end
    #1000;
    rxDrive = 1'b1;
    #(BIT_NS);
    checks++;
    if (rx_busy !== 1'b0 || rx_err !== 1'b0 || rxDoneCount !== doneBefore) begin
      failures++;
      $display("FAIL glitch_reject got=busy%b/err%b/done%0d expected=busy0/err0/done0",
               rx_busy, rx_err, rxDoneCount - doneBefore);
    end
    $display("rx 2us glitch rejected check done");
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    int doneBefore, txBefore, n;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    @(negedge clk);
    loopback   = 1'b1;
    doneBefore = rxDoneCount;
    txBefore   = txDoneCount;
    for (int k = 0; k < 3; k++) expQ.push_back(bytes[k]);
    tx_data  = bytes[0];
    tx_start = 1'b1;
    n = 0;
    while (tx_busy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL loop_tx_start got=timeout expected=busy");
    end
    for (int k = 0; k < 3; k++) begin
      if (k < 2) tx_data = bytes[k+1];
      else tx_start = 1'b0;
      n = 0;
      while (tx_done !== 1'b1 && n < 2 * 10 * BIT_CLKS) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 2 * 10 * BIT_CLKS) begin
        failures++;
        $display("FAIL loop_tx_done k=%0d got=timeout expected=pulse", k);
      end
      @(negedge clk);
    end
    #(BIT_NS);
    checks++;
    if (rxDoneCount - doneBefore !== 3 || expQ.size() !== 0 || txDoneCount - txBefore !== 3) begin
      failures++;
      $display("FAIL loopback_counts got=rx%0d/tx%0d/left%0d expected=rx3/tx3/left0",
               rxDoneCount - doneBefore, txDoneCount - txBefore, expQ.size());
    end
    loopback = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int doneBefore, n;
    @(negedge clk);
    doneBefore = rxDoneCount;
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    n = 0;
    while (tx_out !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL rst_tx_start got=timeout expected=start bit");
    end
    fork
      drive_rx_frame(8'h5A, 1'b1);
      begin
        #(BIT_NS * 4 + BIT_NS / 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_done, rx_busy, rx_err, tx_out, tx_done, tx_busy} !== 14'b00000000_000100) begin
          failures++;
          $display("FAIL reset_midframe got=%b expected=%b",
                   {rx_data, rx_done, rx_busy, rx_err, tx_out, tx_done, tx_busy}, 14'b00000000_000100);
        end
        tx_start = 1'b0;
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS * 12);
    checks++;
    if (rxDoneCount !== doneBefore || rx_busy !== 1'b0 || tx_busy !== 1'b0 || tx_out !== 1'b1 || rx_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=done%0d/rxb%b/txb%b/out%b/err%b expected=done0/rxb0/txb0/out1/err0",
               rxDoneCount - doneBefore, rx_busy, tx_busy, tx_out, rx_err);
    end
    $display("mid-frame reset test complete");
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_good();
    test_rx_framing();
    test_glitch();
    test_loopback();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
